// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART command loader.
// UART_LOADER_CSUM_EN widens err by one bit for the checksum flag.
package uart_loader_pkg;

  typedef enum logic [3:0] {
    OP_LOAD_MAT = 4'd1,
    OP_LOAD_VEC = 4'd2,
    OP_START    = 4'd3,
    OP_CLR_ERR  = 4'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    RUN  = 2'd3
  } state_e;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned LEN_W  = 12;

  localparam int unsigned ERR_OP  = 0;
  localparam int unsigned ERR_LEN = 1;
  localparam int unsigned ERR_OVR = 2;
`ifdef UART_LOADER_CSUM_EN
  localparam int unsigned ERR_CSUM = 3;
  localparam int unsigned ERR_W    = 4;
`else
  localparam int unsigned ERR_W    = 3;
`endif

endpackage

// File: rtl/uart_cmd_loader.sv
// Parses the uart_rx word stream into load/start commands for the MVM core.
// Define UART_LOADER_CSUM_EN to require a trailing XOR checksum word per load.
module uart_cmd_loader
  import uart_loader_pkg::*;
#(
  parameter int W_WORD    = 16,
  parameter int MAT_DEPTH = 256,
  parameter int VEC_DEPTH = 16,
  localparam int MAT_AW   = $clog2(MAT_DEPTH),
  localparam int VEC_AW   = $clog2(VEC_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [W_WORD-1:0] s_data,
  output logic              mat_we,
  output logic [MAT_AW-1:0] mat_addr,
  output logic [W_WORD-1:0] mat_wdata,
  output logic              vec_we,
  output logic [VEC_AW-1:0] vec_addr,
  output logic [W_WORD-1:0] vec_wdata,
  output logic              mvm_start,
  input  logic              mvm_done,
  output logic              busy,
  output logic [ERR_W-1:0]  err
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                tgt_vec_q, tgt_vec_d;
  logic                start_q, start_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                mat_we_q, mat_we_d;
  logic [MAT_AW-1:0]   mat_addr_q, mat_addr_d;
  logic [W_WORD-1:0]   mat_wdata_q, mat_wdata_d;
  logic                vec_we_q, vec_we_d;
  logic [VEC_AW-1:0]   vec_addr_q, vec_addr_d;
  logic [W_WORD-1:0]   vec_wdata_q, vec_wdata_d;
`ifdef UART_LOADER_CSUM_EN
  logic [W_WORD-1:0]   csum_q, csum_d;
`endif

  logic [OP_MSB-OP_LSB:0] hdr_op;
  logic [LEN_W-1:0]       hdr_len;
  logic [LEN_W-1:0]       cnt_inc;
  logic [ERR_W-1:0]       err_set;
  logic                   err_clr;

  assign hdr_op  = s_data[OP_MSB:OP_LSB];
  assign hdr_len = s_data[LEN_W-1:0];
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tgt_vec_d   = tgt_vec_q;
    start_d     = 1'b0;
    mat_we_d    = 1'b0;
    mat_addr_d  = mat_addr_q;
    mat_wdata_d = mat_wdata_q;
    vec_we_d    = 1'b0;
    vec_addr_d  = vec_addr_q;
    vec_wdata_d = vec_wdata_q;
`ifdef UART_LOADER_CSUM_EN
    csum_d      = csum_q;
`endif
    err_set     = '0;
    err_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          case (hdr_op)
            OP_LOAD_MAT, OP_LOAD_VEC: begin
              if (hdr_len == '0) begin
                state_d = IDLE;
              end else if ((hdr_op == OP_LOAD_VEC && 32'(hdr_len) > 32'(VEC_DEPTH)) ||
                           (hdr_op == OP_LOAD_MAT && 32'(hdr_len) > 32'(MAT_DEPTH))) begin
                err_set[ERR_LEN] = 1'b1;
              end else begin
                len_d     = hdr_len;
                cnt_d     = '0;
                tgt_vec_d = (hdr_op == OP_LOAD_VEC);
`ifdef UART_LOADER_CSUM_EN
                csum_d    = '0;
`endif
                state_d   = LOAD;
              end
            end
            OP_START: begin
              start_d = 1'b1;
              state_d = RUN;
            end
            OP_CLR_ERR: err_clr = 1'b1;
            default:    err_set[ERR_OP] = 1'b1;
          endcase
        end
      end

      LOAD: begin
        if (s_valid) begin
          if (tgt_vec_q) begin
            vec_we_d    = 1'b1;
            vec_addr_d  = cnt_q[VEC_AW-1:0];
            vec_wdata_d = s_data;
          end else begin
            mat_we_d    = 1'b1;
            mat_addr_d  = cnt_q[MAT_AW-1:0];
            mat_wdata_d = s_data;
          end
          cnt_d = cnt_inc;
`ifdef UART_LOADER_CSUM_EN
          csum_d = csum_q ^ s_data;
          if (cnt_inc == len_q) state_d = CHK;
`else
          if (cnt_inc == len_q) state_d = IDLE;
`endif
        end
      end

`ifdef UART_LOADER_CSUM_EN
      CHK: begin
        if (s_valid) begin
          if (s_data != csum_q) err_set[ERR_CSUM] = 1'b1;
          state_d = IDLE;
        end
      end
`endif

      RUN: begin
        if (s_valid) err_set[ERR_OVR] = 1'b1;
        if (mvm_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // clear first, then OR in new flags so a same-cycle set survives CLR_ERR
    err_d = (err_clr ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      tgt_vec_q   <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= '0;
      mat_we_q    <= 1'b0;
      mat_addr_q  <= '0;
      mat_wdata_q <= '0;
      vec_we_q    <= 1'b0;
      vec_addr_q  <= '0;
      vec_wdata_q <= '0;
`ifdef UART_LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tgt_vec_q   <= tgt_vec_d;
      start_q     <= start_d;
      err_q       <= err_d;
      mat_we_q    <= mat_we_d;
      mat_addr_q  <= mat_addr_d;
      mat_wdata_q <= mat_wdata_d;
      vec_we_q    <= vec_we_d;
      vec_addr_q  <= vec_addr_d;
      vec_wdata_q <= vec_wdata_d;
`ifdef UART_LOADER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mat_we    = mat_we_q;
  assign mat_addr  = mat_addr_q;
  assign mat_wdata = mat_wdata_q;
  assign vec_we    = vec_we_q;
  assign vec_addr  = vec_addr_q;
  assign vec_wdata = vec_wdata_q;
  assign mvm_start = start_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed bench for uart_cmd_loader; honours UART_LOADER_CSUM_EN when defined.
module tb_uart_cmd_loader;
  import uart_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        mat_we;
  logic [7:0]  mat_addr;
  logic [15:0] mat_wdata;
  logic        vec_we;
  logic [3:0]  vec_addr;
  logic [15:0] vec_wdata;
  logic        mvm_start;
  logic        mvm_done = 1'b0;
  logic        busy;
  logic [ERR_W-1:0] err;

  always #5 clk = ~clk;

  uart_cmd_loader #(.W_WORD(16), .MAT_DEPTH(256), .VEC_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
    .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
    .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .mvm_start(mvm_start), .mvm_done(mvm_done), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // write/start log captured just after each active edge
  logic [15:0] mat_a [0:255];
  logic [15:0] mat_d [0:255];
  logic [15:0] vec_a [0:63];
  logic [15:0] vec_d [0:63];
  int mat_n = 0, vec_n = 0, start_n = 0, both_n = 0;

  always @(posedge clk) begin
    #1;
    if (mat_we) begin
      mat_a[mat_n % 256] = 16'(mat_addr);
      mat_d[mat_n % 256] = mat_wdata;
      mat_n++;
    end
    if (vec_we) begin
      vec_a[vec_n % 64] = 16'(vec_addr);
      vec_d[vec_n % 64] = vec_wdata;
      vec_n++;
    end
    if (mvm_start) start_n++;
    if (mat_we && vec_we) both_n++;
  end

  task automatic send(input logic [15:0] w);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [15:0] x);
`ifdef UART_LOADER_CSUM_EN
    send(x);
`else
    if (x == 16'hFFFF) @(negedge clk);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] t1d [4];
  int mb, vb, sb, wb;
  logic [15:0] x;

  initial begin
    t1d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    // reset state
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mat_we", 32'(mat_we), 32'd0);
    check("rst_vec_we", 32'(vec_we), 32'd0);
    check("rst_start", 32'(mvm_start), 32'd0);

    // 4-word matrix load
    mb = mat_n;
    send(16'h1004);
    check("t1_busy_load", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) send(t1d[i]);
    check("t1_we_last", 32'(mat_we), 32'd1);
    check("t1_addr_last", 32'(mat_addr), 32'd3);
    check("t1_data_last", 32'(mat_wdata), 32'h4444);
`ifdef UART_LOADER_CSUM_EN
    check("t1_busy_chk", 32'(busy), 32'd1);
    send(16'h4444);
`endif
    check("t1_busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_count", 32'(mat_n - mb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 32'(mat_a[(mb + i) % 256]), 32'(i));
      check("t1_data", 32'(mat_d[(mb + i) % 256]), 32'(t1d[i]));
    end

    // zero-length vector load is a no-op
    vb = vec_n;
    send(16'h2000);
    repeat (2) @(negedge clk);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_nowrite", 32'(vec_n - vb), 32'd0);

    // over-length vector header, then single word
    send(16'h2011);
    check("t3_err_len", 32'(err), 32'h2);
    check("t3_busy", 32'(busy), 32'd0);
    send(16'h2001);
    send(16'h5A5A);
    send_csum(16'h5A5A);
    @(negedge clk);
    check("t3_count", 32'(vec_n - vb), 32'd1);
    check("t3_addr", 32'(vec_a[vb % 64]), 32'd0);
    check("t3_data", 32'(vec_d[vb % 64]), 32'h5A5A);

    // exactly VEC_DEPTH words is accepted
    vb = vec_n;
    x = '0;
    send(16'h2010);
    for (int i = 0; i < 16; i++) begin
      send(16'(i * 3 + 1));
      x = x ^ 16'(i * 3 + 1);
    end
    send_csum(x);
    @(negedge clk);
    check("t3_full_count", 32'(vec_n - vb), 32'd16);
    check("t3_full_addr", 32'(vec_a[(vb + 15) % 64]), 32'd15);
    check("t3_full_data", 32'(vec_d[(vb + 15) % 64]), 32'h2E);
    check("t3_full_busy", 32'(busy), 32'd0);

    // clear, then matrix length 257 rejected
    send(16'h4000);
    check("t3_clr", 32'(err), 32'd0);
    send(16'h1101);
    check("t3_mat_len", 32'(err), 32'h2);
    check("t3_mat_busy", 32'(busy), 32'd0);
    send(16'h4000);
    check("t3_clr2", 32'(err), 32'd0);

    // START with overrun word, done after ~10 cycles
    sb = start_n;
    wb = mat_n + vec_n;
    send(16'h3000);
    check("t4_busy_run", 32'(busy), 32'd1);
    send(16'hDEAD);
    check("t4_err_ovr", 32'(err), 32'h4);
    check("t4_busy_wait", 32'(busy), 32'd1);
    repeat (8) @(negedge clk);
    mvm_done = 1'b1;
    @(negedge clk);
    mvm_done = 1'b0;
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_one_start", 32'(start_n - sb), 32'd1);
    check("t4_no_write", 32'(mat_n + vec_n - wb), 32'd0);

    // done outside RUN ignored
    mvm_done = 1'b1;
    @(negedge clk);
    mvm_done = 1'b0;
    @(negedge clk);
    check("t4_done_idle", 32'(busy), 32'd0);
    check("t4_done_nostart", 32'(start_n - sb), 32'd1);

    // done coincident with the start cycle
    sb = start_n;
    send(16'h3000);
    check("t4_start_now", 32'(mvm_start), 32'd1);
    mvm_done = 1'b1;
    @(negedge clk);
    mvm_done = 1'b0;
    check("t4_same_cycle", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_same_starts", 32'(start_n - sb), 32'd1);

    // bad opcodes, clear
    send(16'h4000);
    check("t5_clr_ovr", 32'(err), 32'd0);
    send(16'h7000);
    check("t5_err_op", 32'(err), 32'h1);
    send(16'h4000);
    check("t5_clr_op", 32'(err), 32'd0);

    // reset mid-load abandons the rest
    mb = mat_n;
    send(16'h1004);
    send(16'h0A0A);
    send(16'h0B0B);
    do_reset();
    check("t5_rst_busy", 32'(busy), 32'd0);
    send(16'h0C0C);
    @(negedge clk);
    check("t5_rst_writes", 32'(mat_n - mb), 32'd2);
    check("t5_rst_hdr_op", 32'(err), 32'h1);
    check("t5_rst_idle", 32'(busy), 32'd0);

    // reset during RUN: no second start
    sb = start_n;
    send(16'h3000);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    check("t5_run_rst_busy", 32'(busy), 32'd0);
    check("t5_run_rst_start", 32'(start_n - sb), 32'd1);
    check("t5_run_rst_err", 32'(err), 32'd0);

    check("we_exclusive", 32'(both_n), 32'd0);

`ifdef UART_LOADER_CSUM_EN
    send(16'h1002);
    send(16'h00FF);
    send(16'h0F0F);
    send(16'h0FF0);
    check("t6_csum_ok", 32'(err), 32'd0);
    check("t6_csum_idle", 32'(busy), 32'd0);
    send(16'h1002);
    send(16'h00FF);
    send(16'h0F0F);
    send(16'h0000);
    check("t6_csum_bad", 32'(err), 32'h8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
